// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss handler that fetches one cache block word by word, writes the data array, then pulses the tag write
module cache_fill_fsm #(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int WORDS_PER_BLOCK = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               miss_detected,
   input  logic [ADDR_W-1:0]                  miss_address,
   input  logic [DATA_W-1:0]                  memory_data,
   input  logic                               memory_data_valid,
   output logic                               fsm_busy,
   output logic                               memory_read_en,
   output logic [ADDR_W-1:0]                  memory_address,
   output logic                               write_data_array,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_offset,
   output logic [DATA_W-1:0]                  fill_data,
   output logic                               write_tag_array
);
   localparam int IW = $clog2(WORDS_PER_BLOCK);
   localparam int CW = IW + 1;
   localparam int WS = $clog2(DATA_W / 8);
   localparam int BS = IW + WS;
   typedef enum logic [1:0] {IDLE, FILL, WRTAG} state_t;
   state_t            state, state_nx;
   logic [CW-1:0]     req_cnt, rcv_cnt;
   logic [ADDR_W-1:0] base_addr;
   logic              accept;
   // Request and return counters run independently; req_cnt saturates at WORDS_PER_BLOCK
   always_comb begin
      accept           = state == IDLE && miss_detected;
      fsm_busy         = state != IDLE;
      memory_read_en   = state == FILL && !req_cnt[IW];
      memory_address   = memory_read_en ? base_addr + (ADDR_W'(req_cnt) << WS) : '0;
      write_data_array = state == FILL && memory_data_valid;
      data_word_offset = write_data_array ? rcv_cnt[IW-1:0] : '0;
      fill_data        = memory_data;
      write_tag_array  = state == WRTAG;
      state_nx         = accept ? FILL
                       : (write_data_array && rcv_cnt == CW'(WORDS_PER_BLOCK - 1)) ? WRTAG
                       : state == WRTAG ? IDLE
                       : state;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         req_cnt   <= '0;
         rcv_cnt   <= '0;
         base_addr <= '0;
      end else begin
         state   <= state_nx;
         req_cnt <= accept ? '0 : req_cnt + CW'(memory_read_en);
         rcv_cnt <= accept ? '0 : rcv_cnt + CW'(write_data_array);
         if (accept) base_addr <= miss_address & ~ADDR_W'(2 ** BS - 1);
      end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed fills against a pipelined memory model and a block-level reference model
module tb_cache_fill_fsm;
   logic        clk = 1'b0;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic [15:0] memory_data;
   logic        memory_data_valid;
   logic        fsm_busy;
   logic        memory_read_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  data_word_offset;
   logic [15:0] fill_data;
   logic        write_tag_array;

   int errors = 0;
   int checks = 0;
   int phase, req, rcv, base;
   int mode, gap;
   bit spur;
   logic [15:0] pend[$];
   int obs_busy, obs_tag, obs_wr, obs_req;

   cache_fill_fsm dut (
      .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
      .memory_data(memory_data), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
      .memory_read_en(memory_read_en), .memory_address(memory_address),
      .write_data_array(write_data_array), .data_word_offset(data_word_offset),
      .fill_data(fill_data), .write_tag_array(write_tag_array)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input int a);
      return 16'(a) ^ 16'hC3A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit miss, input logic [15:0] ma);
      bit v;
      bit rd;
      miss_detected = miss;
      miss_address  = ma;
      case (mode)
         0:       v = pend.size() > 0;
         1:       v = pend.size() > 0 && (gap % 3 == 0);
         default: v = pend.size() > 0 && $urandom_range(1, 0) == 1;
      endcase
      if (spur) v = 1'b1;
      gap++;
      memory_data_valid = v;
      memory_data       = pend.size() > 0 ? mem_word(int'(pend[0])) : 16'($urandom);
      @(negedge clk);
      rd = phase == 1 && req < 8;
      chk("busy", 32'(fsm_busy), 32'(phase != 0));
      chk("read_en", 32'(memory_read_en), 32'(rd));
      chk("tag", 32'(write_tag_array), 32'(phase == 2));
      chk("write", 32'(write_data_array), 32'(phase == 1 && v));
      chk("fill_data", 32'(fill_data), 32'(memory_data));
      if (rd) chk("address", 32'(memory_address), 32'(base + 2 * req));
      if (phase == 1 && v) begin
         chk("offset", 32'(data_word_offset), 32'(rcv));
         chk("word", 32'(fill_data), 32'(mem_word(base + 2 * rcv)));
      end
      obs_busy += int'(fsm_busy);
      obs_tag  += int'(write_tag_array);
      obs_wr   += int'(write_data_array);
      obs_req  += int'(memory_read_en);
      if (v && pend.size() > 0) void'(pend.pop_front());
      if (memory_read_en) pend.push_back(memory_address);
      case (phase)
         0: if (miss) begin
               phase = 1;
               base  = int'(ma) / 16 * 16;
               req   = 0;
               rcv   = 0;
            end
         1: begin
               if (req < 8) req++;
               if (v) begin
                  rcv++;
                  if (rcv == 8) phase = 2;
               end
            end
         default: phase = 0;
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [15:0] a, input int m, input bit stray, input bit exact);
      int n = 0;
      mode = m;
      gap = 0;
      obs_busy = 0; obs_tag = 0; obs_wr = 0; obs_req = 0;
      cyc(1'b1, a);
      while (phase != 0 && n < 300) begin
         cyc(stray && n >= 2 && n < 5, 16'h5550);
         n++;
      end
      chk("fill_done", 32'(fsm_busy), 32'd0);
      chk("tag_pulses", 32'(obs_tag), 32'd1);
      chk("data_writes", 32'(obs_wr), 32'd8);
      chk("requests", 32'(obs_req), 32'd8);
      chk("outstanding", 32'(pend.size()), 32'd0);
      if (exact) chk("busy_cycles", 32'(obs_busy), 32'd10);
   endtask

   initial begin
      phase = 0; req = 0; rcv = 0; base = 0; mode = 0; gap = 0; spur = 1'b0;
      rst = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
      memory_data = 16'h0; memory_data_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_busy", 32'(fsm_busy), 32'd0);
         chk("rst_read_en", 32'(memory_read_en), 32'd0);
         chk("rst_address", 32'(memory_address), 32'd0);
         chk("rst_write", 32'(write_data_array), 32'd0);
         chk("rst_offset", 32'(data_word_offset), 32'd0);
         chk("rst_tag", 32'(write_tag_array), 32'd0);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0);

      fill(16'h1234, 0, 1'b0, 1'b1);
      fill(16'h2A07, 1, 1'b0, 1'b0);
      fill(16'h4321, 0, 1'b1, 1'b1);
      spur = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0);
      spur = 1'b0;
      fill(16'h0ABC, 0, 1'b0, 1'b1);

      obs_wr = 0;
      mode = 0;
      gap = 0;
      cyc(1'b1, 16'h7777);
      for (int n = 0; n < 50 && obs_wr < 3; n++) cyc(1'b0, 16'h0);
      rst = 1'b0;
      #1;
      chk("abort_busy", 32'(fsm_busy), 32'd0);
      chk("abort_read_en", 32'(memory_read_en), 32'd0);
      chk("abort_tag", 32'(write_tag_array), 32'd0);
      chk("abort_write", 32'(write_data_array), 32'd0);
      phase = 0;
      pend.delete();
      memory_data_valid = 1'b0;
      miss_detected = 1'b0;
      @(negedge clk);
      chk("abort_held_busy", 32'(fsm_busy), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      fill(16'h7777, 0, 1'b0, 1'b1);

      fill(16'hFFFF, 0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) fill(16'($urandom), 2, k[0], 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
